// File: rtl/simon_spi_slave.sv
// SPI mode-0 slave front-end for the SIMON 32/64 core: collects key and plaintext,
// pulses start, and returns ciphertext and status bytes. Everything runs on clk.
module simon_spi_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int KEY_BYTES   = 8,
    parameter int BLK_BYTES   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   spi_sclk,
    input  logic                   spi_cs_n,
    input  logic                   spi_mosi,
    output logic                   spi_miso,
    output logic [KEY_BYTES*8-1:0] key_o,
    output logic [BLK_BYTES*8-1:0] pt_o,
    output logic                   start_o,
    input  logic [BLK_BYTES*8-1:0] ct_i,
    input  logic                   done_i,
    input  logic                   busy_i
);

    localparam int KW = KEY_BYTES * 8;
    localparam int BW = BLK_BYTES * 8;
    localparam logic [7:0] KEY_LAST = 8'(KEY_BYTES - 1);
    localparam logic [7:0] BLK_LAST = 8'(BLK_BYTES - 1);

    typedef enum logic [2:0] {IDLE, CMD, WKEY, WBLK, RCT, RSTAT, IGNORE} state_t;

    state_t                   state;
    logic [SYNC_STAGES-1:0]   sclk_sync;
    logic [SYNC_STAGES-1:0]   cs_sync;
    logic [SYNC_STAGES-1:0]   mosi_sync;
    logic                     sclk_prev;
    logic                     cs_prev;
    logic [2:0]               bit_cnt;
    logic [7:0]               byte_cnt;
    logic [6:0]               rx_shift;
    logic [BW-1:0]            tx_shift;
    logic                     miso_q;
    logic [KW-9:0]            key_shadow;
    logic [BW-9:0]            pt_shadow;
    logic [BW-1:0]            ct_reg;
    logic                     done_flag;
    logic                     overrun;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic byte_done;
    logic [7:0] rx_byte;
    logic ovr_set, ovr_clr, done_clr;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;
    assign cs_rise   = cs_s & ~cs_prev;
    assign cs_fall   = ~cs_s & cs_prev;
    assign rx_byte   = {rx_shift, mosi_s};
    assign byte_done = sclk_rise && !cs_s && !cs_rise && !cs_fall &&
                       (state != IDLE) && (bit_cnt == 3'd7);
    assign ovr_set   = byte_done && (state == WBLK) && (byte_cnt == BLK_LAST) && busy_i;
    assign ovr_clr   = byte_done && (state == RSTAT) && (byte_cnt == 8'd0);
    assign done_clr  = byte_done && (state == RCT) && (byte_cnt == BLK_LAST);
    assign spi_miso  = miso_q & ~cs_s;

    // Chip select resets to its idle (deasserted) level so reset release is not seen as a frame start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev <= sclk_s;
            cs_prev   <= cs_s;
        end
    end

    // A done pulse that coincides with a read-clear keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ct_reg    <= '0;
            done_flag <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (done_i) begin
                ct_reg <= ct_i;
            end
            done_flag <= done_i | (done_flag & ~done_clr);
            overrun   <= ovr_set | (overrun & ~ovr_clr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            miso_q     <= 1'b0;
            key_shadow <= '0;
            pt_shadow  <= '0;
            key_o      <= '0;
            pt_o       <= '0;
            start_o    <= 1'b0;
        end else begin
            start_o <= 1'b0;
            if (cs_rise || cs_fall) begin
                state    <= cs_fall ? CMD : IDLE;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                rx_shift <= '0;
                tx_shift <= '0;
                miso_q   <= 1'b0;
            end else if (state != IDLE && !cs_s) begin
                if (sclk_rise) begin
                    rx_shift <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (state != CMD && byte_cnt != 8'hFF) begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end
                        case (state)
                            CMD: begin
                                case (rx_byte)
                                    8'h01: state <= WKEY;
                                    8'h02: state <= WBLK;
                                    8'h03: begin
                                        state    <= RCT;
                                        tx_shift <= ct_reg;
                                    end
                                    8'h04: begin
                                        state    <= RSTAT;
                                        tx_shift <= {5'b0, overrun, done_flag, busy_i, {(BW-8){1'b0}}};
                                    end
                                    default: state <= IGNORE;
                                endcase
                            end
                            WKEY: begin
                                if (byte_cnt <= KEY_LAST) begin
                                    key_shadow <= {key_shadow[KW-17:0], rx_byte};
                                    if (byte_cnt == KEY_LAST) begin
                                        key_o <= {key_shadow, rx_byte};
                                    end
                                end
                            end
                            WBLK: begin
                                if (byte_cnt <= BLK_LAST) begin
                                    pt_shadow <= {pt_shadow[BW-17:0], rx_byte};
                                    if (byte_cnt == BLK_LAST && !busy_i) begin
                                        pt_o    <= {pt_shadow, rx_byte};
                                        start_o <= 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                // tx_shift is zero outside the read states, so miso idles low there.
                if (sclk_fall) begin
                    miso_q   <= tx_shift[BW-1];
                    tx_shift <= {tx_shift[BW-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: doc/simon_spi_slave.md
Name: simon_spi_slave

Overview:
SPI-mode-0 slave front-end for the SIMON 32/64 cipher. Sits between the chip pins and the SIMON core. It holds the 64-bit key and the 32-bit plaintext written over SPI, and pulses start to the core. It captures the core's ciphertext and returns it, with a status byte, on SPI reads. All logic runs in the system clock domain; SPI pins are oversampled.

Parameters:
SYNC_STAGES, 2, synchronizer depth on spi_sclk, spi_cs_n and spi_mosi (minimum 2)
KEY_BYTES, 8, key length in bytes (64-bit key)
BLK_BYTES, 4, block length in bytes (32-bit block)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
spi_sclk  in  1  SPI clock, idle low (mode 0)
spi_cs_n  in  1  chip select, active low
spi_mosi  in  1  master-out data, MSB first
spi_miso  out  1  slave-out data, MSB first; 0 while spi_cs_n high
key_o  out  64  committed key to core
pt_o  out  32  committed plaintext to core
start_o  out  1  one-cycle start pulse to core
ct_i  in  32  ciphertext from core
done_i  in  1  one-cycle pulse: ct_i valid
busy_i  in  1  core busy

Behaviour:
- Reset (async, rst=1): key_o=0, pt_o=0, start_o=0, spi_miso=0; all flags, counters and shift registers cleared; FSM to IDLE.
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized sclk and cs_n. sclk frequency must be ≤ clk/8.
- Sampling: mosi is sampled on each sclk rising edge. Miso updates on each sclk falling edge. Bit counter 0..7; a byte completes on the 8th rising edge.
- FSM states:
  - IDLE: waits for cs_n falling edge, then clears the bit and byte counters and moves to CMD.
  - CMD: first byte is the command. 0x01 → WKEY. 0x02 → WBLK. 0x03 → RCT. 0x04 → RSTAT. Any other value → IGNORE.
  - WKEY: each completed byte shifts into the key shadow register: shadow={shadow[55:0],byte}. On completion of byte KEY_BYTES, key_o<=shadow. Further bytes are ignored.
  - WBLK: bytes shift into the pt shadow register the same way. On completion of byte BLK_BYTES:
    - if busy_i=0: pt_o<=shadow and start_o=1 for exactly one clk.
    - if busy_i=1: pt_o is unchanged, no start, and overrun is set.
  - RCT: on entry, tx shift register <= ct_reg. Bit 31 appears on miso at the falling edge that follows the command byte; 32 bits total, then zeros. done_flag clears when the 4th byte completes.
  - RSTAT: tx register <= {5'b0, overrun, done_flag, busy_i}, sent as one byte, then zeros. Overrun clears when the status byte completes.
  - IGNORE: miso=0 and nothing is written.
- From any state, a cs_n rising edge returns the FSM to IDLE. A partial frame commits nothing: key_o and pt_o keep their prior values. Counters are discarded.
- Core result capture: done_i=1 captures ct_i into ct_reg and sets done_flag. If done_i and a flag clear occur in the same cycle, the set wins.
- A cs_n falling edge while in a non-IDLE state (glitch) restarts at CMD.
- spi_miso is forced to 0 whenever synchronized cs_n=1.

Test Plan:
- Key write: reset, then frame 0x01 followed by bytes 0x19,0x18,0x11,0x10,0x09,0x08,0x01,0x00 → key_o=64'h1918111009080100 after the 8th byte.
- Block write and start: busy_i=0, frame 0x02 followed by 0x65,0x65,0x68,0x77 → pt_o=32'h65656877 and start_o high for exactly 1 clk.
- Overrun: busy_i=1 during a block write → start_o stays 0 and pt_o is unchanged. A subsequent 0x04 read returns 0x05 (overrun and busy set). A second 0x04 read with busy_i=0 returns 0x00.
- Result readback: pulse done_i with ct_i=32'hC69BE9BB → 0x04 read returns 0x02. Then a 0x03 read shifts out C6,9B,E9,BB on miso. A following 0x04 read returns 0x00.
- Aborted frame: 0x01 plus only 3 key bytes, then cs_n high → key_o keeps its prior value; the next full frame commits correctly.
- Reset mid-frame: assert rst during the 2nd byte of a WBLK frame → all outputs 0 immediately; after release, a fresh frame works.
